event_counter_arbiter: RTL

Time-shares one tick counter among NUM_REQ requesters, each of which asks for a delay of a programmed number of TICK rising edges. A round-robin arbiter grants one requester at a time, clears the shared counter, counts TICK edges up to that requester's target, and then pulses DONE back to it. The block sits between the protocol FSMs that need tick-based timeouts and the system tick source, so each FSM does not need its own counter.

---
 rtl/event_pkg.sv | 11 +
 rtl/event_counter_arbiter_if.sv | 15 +
 rtl/rr_arbiter.sv | 22 ++
 rtl/event_counter_arbiter.sv | 86 ++++++++
 4 files changed

// File: rtl/event_pkg.sv
// event_pkg: shared FSM encoding and packed-slice helper for the tick-counter arbiter
package event_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, FIN = 2'd2} state_t;
    localparam int MAX_W = 16;
    localparam int MAX_VEC = 128;
    function automatic logic [MAX_W-1:0] target_slice(input logic [MAX_VEC-1:0] vec, input int i, input int w);
        logic [MAX_VEC-1:0] s;
        s = vec >> (i * w);
        return s[MAX_W-1:0] & ((MAX_W'(1) << w) - MAX_W'(1));
    endfunction
endpackage

// File: rtl/event_counter_arbiter_if.sv
// event_counter_arbiter_if: requester-side bundle of tick, requests, targets and grant/done status
interface event_counter_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int TARGET_WIDTH = 4
);
    logic tick;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ*TARGET_WIDTH-1:0] req_target;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] done;
    logic busy;
    logic [TARGET_WIDTH-1:0] counter;
    modport master(output tick, req, req_target, input grant, done, busy, counter);
    modport slave(input tick, req, req_target, output grant, done, busy, counter);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic [2*N-1:0] req2;
    logic [2*N-1:0] gnt2;
    logic [N-1:0] first;
    // rotate so ptr sits at bit 0, take the lowest set bit, rotate back
    always_comb begin
        req2 = {req, req} >> ptr;
        first = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req2[k]) first = N'(1) << k;
        gnt2 = {first, first} << ptr;
        gnt = gnt2[2*N-1:N];
    end
endmodule

// File: rtl/event_counter_arbiter.sv
// event_counter_arbiter: time-shares one tick counter among round-robin granted requesters
module event_counter_arbiter
    import event_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TARGET_WIDTH = 4
) (
    input logic ACLK,
    input logic ARESETN,
    event_counter_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    state_t state;
    logic [IW-1:0] ptr, owner, win;
    logic [NUM_REQ-1:0] arb_gnt, grant, done;
    logic [TARGET_WIDTH-1:0] tgt, cnt, cnt_inc, win_tgt;
    logic tick_d, busy, tick_edge;

    rr_arbiter #(.N(NUM_REQ)) u_arb (.req(bus.req), .ptr(ptr), .gnt(arb_gnt));

    // winner index from the one-hot grant
    always_comb begin
        win = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (arb_gnt[k]) win = IW'(k);
    end

    assign win_tgt = TARGET_WIDTH'(target_slice(MAX_VEC'(bus.req_target), int'(win), TARGET_WIDTH));
    assign tick_edge = bus.tick & ~tick_d;
    assign cnt_inc = cnt + TARGET_WIDTH'(1);
    assign bus.grant = grant;
    assign bus.done = done;
    assign bus.busy = busy;
    assign bus.counter = cnt;

    // grant, count, finish; IDLE first retires a finished grant before arbitrating again
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
            ptr <= '0;
            owner <= '0;
            tgt <= '0;
            cnt <= '0;
            tick_d <= 1'b0;
            grant <= '0;
            done <= '0;
            busy <= 1'b0;
        end else begin
            tick_d <= bus.tick;
            done <= '0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        grant <= '0;
                        cnt <= '0;
                    end else if (|bus.req) begin
                        grant <= arb_gnt;
                        owner <= win;
                        tgt <= win_tgt;
                        cnt <= '0;
                        ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
                        busy <= 1'b1;
                        state <= (win_tgt == '0) ? FIN : COUNT;
                    end
                end
                COUNT: begin
                    if (!bus.req[owner]) begin
                        grant <= '0;
                        cnt <= '0;
                        busy <= 1'b0;
                        state <= IDLE;
                    end else if (tick_edge) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == tgt) state <= FIN;
                    end
                end
                FIN: begin
                    done <= grant;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
